// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_decoder
// Description : Passive monitor for a multiplexed 7-segment bus. Recovers the
//               hex nibble and decimal point shown on every digit position,
//               flags illegal cathode patterns, reports completed scan frames
//               and scan stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_decoder #(
  parameter int                    NUM_DIGITS     = 8,
  parameter int                    SETTLE_CYCLES  = 16,
  parameter int                    TIMEOUT_CYCLES = 200000,
  parameter logic [NUM_DIGITS-1:0] SCAN_MASK      = {NUM_DIGITS{1'b1}}
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic [7:0]              ca,
  input  logic [NUM_DIGITS-1:0]   an,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   dp,
  output logic [NUM_DIGITS-1:0]   valid,
  output logic [NUM_DIGITS-1:0]   err,
  output logic                    frame_done,
  output logic                    stale
);

  localparam int                PAIR_W      = 8 + NUM_DIGITS;
  localparam int                IDLE_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]        SETTLE_LAST = 8'(SETTLE_CYCLES - 2);
  localparam logic [IDLE_W-1:0] IDLE_MAX    = IDLE_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    SETTLE  = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [7:0]          settle_cnt, settle_cnt_next;
  logic [PAIR_W-1:0]   sync1, sync2, pair_prev;
  logic [IDLE_W-1:0]   idle_cnt, idle_cnt_next;
  logic [NUM_DIGITS-1:0] seen, seen_next, seen_base;
  logic [NUM_DIGITS-1:0] sel;
  logic [NUM_DIGITS-1:0] dp_next, valid_next, err_next;
  logic [4*NUM_DIGITS-1:0] digits_next;
  logic                frame_next;
  logic                changed, do_cap;
  logic [4:0]          dec;
  logic [6:0]          cap_seg;
  logic                cap_dp_n;

  // Returns {legal, nibble} for an active-low g..a segment pattern.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    logic [4:0] r;
    r = 5'h00;
    case (seg)
      7'h40: r = 5'h10;
      7'h79: r = 5'h11;
      7'h24: r = 5'h12;
      7'h30: r = 5'h13;
      7'h19: r = 5'h14;
      7'h12: r = 5'h15;
      7'h02: r = 5'h16;
      7'h78: r = 5'h17;
      7'h00: r = 5'h18;
      7'h10: r = 5'h19;
      7'h08: r = 5'h1A;
      7'h03: r = 5'h1B;
      7'h46: r = 5'h1C;
      7'h21: r = 5'h1D;
      7'h06: r = 5'h1E;
      7'h0E: r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  // The capture uses pair_prev, which holds the value that was counted stable
  // even if the bus moves during the CAPTURE cycle itself.
  assign changed  = (sync2 != pair_prev);
  assign cap_dp_n = pair_prev[PAIR_W-1];
  assign cap_seg  = pair_prev[PAIR_W-2:NUM_DIGITS];
  assign sel      = ~pair_prev[NUM_DIGITS-1:0];
  assign do_cap   = (state == CAPTURE) && $onehot(sel);
  assign dec      = decode_seg(cap_seg);
  assign stale    = (idle_cnt == IDLE_MAX);

  // Two-flop synchronizers plus the previous-cycle copy; the copy is frozen
  // during CAPTURE so a change in that cycle is still seen from HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= '1;
      sync2     <= '1;
      pair_prev <= '1;
    end else begin
      sync1 <= {ca, an};
      sync2 <= sync1;
      if (state != CAPTURE) begin
        pair_prev <= sync2;
      end
    end
  end

  // FSM state and stability counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SETTLE;
      settle_cnt <= 8'd0;
    end else begin
      state      <= state_next;
      settle_cnt <= settle_cnt_next;
    end
  end

  // Next-state: count stable cycles, capture once, then wait for a change.
  always_comb begin
    state_next      = state;
    settle_cnt_next = settle_cnt;
    case (state)
      SETTLE: begin
        if (changed) begin
          settle_cnt_next = 8'd0;
        end else if (settle_cnt == SETTLE_LAST) begin
          settle_cnt_next = settle_cnt + 8'd1;
          state_next      = CAPTURE;
        end else begin
          settle_cnt_next = settle_cnt + 8'd1;
        end
      end
      CAPTURE: begin
        settle_cnt_next = 8'd0;
        state_next      = HOLD;
      end
      HOLD: begin
        if (changed) begin
          settle_cnt_next = 8'd0;
          state_next      = SETTLE;
        end
      end
      default: begin
        settle_cnt_next = 8'd0;
        state_next      = SETTLE;
      end
    endcase
  end

  // Capture datapath: clear first, then apply the captured digit on top.
  always_comb begin
    digits_next   = digits;
    dp_next       = dp;
    valid_next    = clr ? '0 : valid;
    err_next      = clr ? '0 : err;
    seen_base     = clr ? '0 : seen;
    seen_next     = seen_base;
    frame_next    = 1'b0;
    idle_cnt_next = (idle_cnt == IDLE_MAX) ? idle_cnt : idle_cnt + IDLE_W'(1);
    if (do_cap) begin
      idle_cnt_next = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (sel[i]) begin
          dp_next[i] = ~cap_dp_n;
          if (dec[4]) begin
            digits_next[4*i +: 4] = dec[3:0];
            valid_next[i]         = 1'b1;
          end else if (cap_seg == 7'h7F) begin
            valid_next[i] = 1'b0;
          end else begin
            err_next[i] = 1'b1;
          end
        end
      end
      if (((seen_base | sel) & SCAN_MASK) == SCAN_MASK) begin
        frame_next = 1'b1;
        seen_next  = '0;
      end else begin
        seen_next = seen_base | sel;
      end
    end
  end

  // Output, frame-tracking and idle-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits     <= '0;
      dp         <= '0;
      valid      <= '0;
      err        <= '0;
      seen       <= '0;
      frame_done <= 1'b0;
      idle_cnt   <= '0;
    end else begin
      digits     <= digits_next;
      dp         <= dp_next;
      valid      <= valid_next;
      err        <= err_next;
      seen       <= seen_next;
      frame_done <= frame_next;
      idle_cnt   <= idle_cnt_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_decoder
// Description : Self-checking bench for seg_scan_decoder with a run-length
//               reference model of the scan bus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_decoder;
  localparam int ND = 8;
  localparam int S  = 16;
  localparam int T  = 100;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr   = 1'b0;
  logic [7:0]  ca    = 8'hFF;
  logic [7:0]  an    = 8'hFF;
  logic [31:0] digits;
  logic [7:0]  dp, valid, err;
  logic        frame_done, stale;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg_scan_decoder #(
    .NUM_DIGITS(ND), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T), .SCAN_MASK(8'hFF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .ca(ca), .an(an),
    .digits(digits), .dp(dp), .valid(valid), .err(err),
    .frame_done(frame_done), .stale(stale)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // A pair seen for S consecutive samples is captured 3 edges after the S-th
  // sample (i.e. S+2 edges after the first one); one capture per run.
  logic [31:0] m_digits = '0;
  logic [7:0]  m_dp = '0, m_valid = '0, m_err = '0, m_seen = '0;
  logic        m_fd = 1'b0, m_stale = 1'b0;
  int          m_idle = 0, run_len = 0;
  logic [15:0] run_val = '1;
  logic        p_v [1:3] = '{1'b0, 1'b0, 1'b0};
  logic [15:0] p_d [1:3] = '{16'h0, 16'h0, 16'h0};
  logic        m_due, m_capt;
  logic [15:0] m_dv, m_s;
  int          m_d, m_idx;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_digits = '0; m_dp = '0; m_valid = '0; m_err = '0; m_seen = '0;
      m_fd = 1'b0; m_stale = 1'b0; m_idle = 0; run_len = 0; run_val = '1;
      for (int i = 1; i <= 3; i++) p_v[i] = 1'b0;
    end else begin
      m_s   = {ca, an};
      m_due = p_v[1];
      m_dv  = p_d[1];
      p_v[1] = p_v[2]; p_d[1] = p_d[2];
      p_v[2] = p_v[3]; p_d[2] = p_d[3];
      p_v[3] = 1'b0;
      if (run_len > 0 && m_s == run_val) run_len++;
      else begin run_val = m_s; run_len = 1; end
      if (run_len == S) begin p_v[3] = 1'b1; p_d[3] = run_val; end

      m_fd   = 1'b0;
      m_capt = 1'b0;
      if (clr) begin m_valid = '0; m_err = '0; m_seen = '0; end
      if (m_due && $countones(~m_dv[7:0]) == 1) begin
        m_capt = 1'b1;
        m_d = 0;
        for (int i = 0; i < 8; i++) if (!m_dv[i]) m_d = i;
        m_dp[m_d] = ~m_dv[15];
        m_idx = -1;
        for (int j = 0; j < 16; j++) if (seg_tab[j] == m_dv[14:8]) m_idx = j;
        if (m_idx >= 0) begin
          m_digits[4*m_d +: 4] = 4'(m_idx);
          m_valid[m_d] = 1'b1;
        end else if (m_dv[14:8] == 7'h7F) begin
          m_valid[m_d] = 1'b0;
        end else begin
          m_err[m_d] = 1'b1;
        end
        m_seen[m_d] = 1'b1;
        if (m_seen == 8'hFF) begin m_fd = 1'b1; m_seen = '0; end
      end
      if (m_capt) m_idle = 0;
      else if (m_idle < T) m_idle++;
      m_stale = (m_idle >= T);
    end
  end

  function automatic logic [57:0] obs_v();
    return {digits, dp, valid, err, frame_done, stale};
  endfunction

  function automatic logic [57:0] exp_v();
    return {m_digits, m_dp, m_valid, m_err, m_fd, m_stale};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ca = 8'($urandom); an = 8'($urandom);
      @(negedge clk);
      n_cmp++;
      if (obs_v() !== 58'h0) begin n_fail++; $display("FAIL reset_hold: got %h expected 0", obs_v()); end
    end
    an = 8'hFF; ca = 8'($urandom);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs_v() !== exp_v()) begin n_fail++; $display("FAIL reset_blank_model: got %h expected %h", obs_v(), exp_v()); end
      n_cmp++;
      if (frame_done !== 1'b0 || valid !== 8'h00) begin
        n_fail++; $display("FAIL reset_blank: got fd=%b valid=%h expected fd=0 valid=00", frame_done, valid);
      end
    end
  endtask

  task automatic test_single_digit();
    an = 8'hFE; ca = 8'h8E;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs_v() !== exp_v()) begin n_fail++; $display("FAIL single_model: got %h expected %h", obs_v(), exp_v()); end
      if (i == 18) begin
        n_cmp++;
        if (valid[0] !== 1'b0) begin n_fail++; $display("FAIL single_early: got valid0=%b expected 0", valid[0]); end
      end
      if (i == 19) begin
        n_cmp++;
        if ({digits[3:0], valid[0], dp[0]} !== 6'b1111_1_0) begin
          n_fail++; $display("FAIL single_latency: got dig=%h v=%b dp=%b expected dig=f v=1 dp=0", digits[3:0], valid[0], dp[0]);
        end
      end
    end
    ca = 8'h0E;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs_v() !== exp_v()) begin n_fail++; $display("FAIL single_dp_model: got %h expected %h", obs_v(), exp_v()); end
    end
    n_cmp++;
    if ({dp[0], digits[3:0]} !== 5'h1F) begin n_fail++; $display("FAIL single_dp: got dp=%b dig=%h expected dp=1 dig=f", dp[0], digits[3:0]); end
  endtask

  task automatic test_glitch();
    an = 8'hFD;
    for (int i = 0; i < 200; i++) begin
      if (i % 8 == 0) ca = ((i / 8) % 2 == 0) ? 8'hC0 : 8'hF9;
      @(negedge clk);
      n_cmp++;
      if (obs_v() !== exp_v()) begin n_fail++; $display("FAIL glitch_model: got %h expected %h", obs_v(), exp_v()); end
    end
    n_cmp++;
    if (valid[1] !== 1'b0 || digits[7:4] !== 4'h0) begin
      n_fail++; $display("FAIL glitch_reject: got v1=%b dig1=%h expected v1=0 dig1=0", valid[1], digits[7:4]);
    end
    ca = 8'hF9;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs_v() !== exp_v()) begin n_fail++; $display("FAIL glitch_hold_model: got %h expected %h", obs_v(), exp_v()); end
    end
    n_cmp++;
    if (valid[1] !== 1'b1 || digits[7:4] !== 4'h1) begin
      n_fail++; $display("FAIL glitch_hold: got v1=%b dig1=%h expected v1=1 dig1=1", valid[1], digits[7:4]);
    end
  endtask

  task automatic test_illegal_blank();
    logic [7:0] pats [3];
    pats = '{8'hFF, 8'hAA, 8'hA4};
    an = 8'hFB;
    for (int p = 0; p < 3; p++) begin
      ca = pats[p];
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        n_cmp++;
        if (obs_v() !== exp_v()) begin n_fail++; $display("FAIL illegal_model: got %h expected %h", obs_v(), exp_v()); end
      end
      if (p == 0) begin
        n_cmp++;
        if (valid[2] !== 1'b0 || err !== 8'h00) begin n_fail++; $display("FAIL blank_digit: got v2=%b err=%h expected v2=0 err=00", valid[2], err); end
      end else if (p == 1) begin
        n_cmp++;
        if (err !== 8'h04) begin n_fail++; $display("FAIL illegal_err: got err=%h expected 04", err); end
      end else begin
        n_cmp++;
        if (err[2] !== 1'b1 || valid[2] !== 1'b1 || digits[11:8] !== 4'h2) begin
          n_fail++; $display("FAIL err_sticky: got e2=%b v2=%b dig2=%h expected e2=1 v2=1 dig2=2", err[2], valid[2], digits[11:8]);
        end
      end
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs_v() !== exp_v()) begin n_fail++; $display("FAIL clr_model: got %h expected %h", obs_v(), exp_v()); end
    end
    n_cmp++;
    if (err !== 8'h00 || valid !== 8'h00 || digits[11:8] !== 4'h2) begin
      n_fail++; $display("FAIL clr_pulse: got err=%h valid=%h dig2=%h expected 00 00 2", err, valid, digits[11:8]);
    end
  endtask

  task automatic test_full_frame();
    int fd_cnt;
    logic fd_ok;
    fd_cnt = 0; fd_ok = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    for (int d = 0; d < 8; d++) begin
      an = 8'(~(8'b1 << d));
      ca = {1'b1, seg_tab[d]};
      for (int i = 1; i <= 50; i++) begin
        @(negedge clk);
        n_cmp++;
        if (obs_v() !== exp_v()) begin n_fail++; $display("FAIL frame_model: got %h expected %h", obs_v(), exp_v()); end
        if (frame_done === 1'b1) begin
          fd_cnt++;
          if (d == 7 && i == 19) fd_ok = 1'b1;
        end
      end
    end
    n_cmp++;
    if (fd_cnt != 1 || !fd_ok) begin n_fail++; $display("FAIL frame_pulse: got %0d pulses aligned=%b expected 1 aligned=1", fd_cnt, fd_ok); end
    n_cmp++;
    if (digits !== 32'h76543210 || valid !== 8'hFF) begin
      n_fail++; $display("FAIL frame_digits: got %h valid=%h expected 76543210 valid=ff", digits, valid);
    end
  endtask

  task automatic test_clr_with_capture();
    an = 8'hF7; ca = 8'h99;
    for (int i = 1; i <= 30; i++) begin
      clr = (i == 19);
      @(negedge clk);
      n_cmp++;
      if (obs_v() !== exp_v()) begin n_fail++; $display("FAIL clr_cap_model: got %h expected %h", obs_v(), exp_v()); end
      if (i == 19) begin
        n_cmp++;
        if (valid !== 8'h08 || err !== 8'h00 || digits[15:12] !== 4'h4) begin
          n_fail++; $display("FAIL clr_cap: got valid=%h err=%h dig3=%h expected 08 00 4", valid, err, digits[15:12]);
        end
      end
    end
    clr = 1'b0;
  endtask

  task automatic test_stall();
    an = 8'hFE; ca = 8'hC0;
    for (int t = 1; t <= 150; t++) begin
      if (t == 31) an = 8'hFF;
      @(negedge clk);
      n_cmp++;
      if (obs_v() !== exp_v()) begin n_fail++; $display("FAIL stall_model: got %h expected %h", obs_v(), exp_v()); end
      if (t == 118) begin
        n_cmp++;
        if (stale !== 1'b0) begin n_fail++; $display("FAIL stale_early: got %b expected 0", stale); end
      end
      if (t == 119) begin
        n_cmp++;
        if (stale !== 1'b1) begin n_fail++; $display("FAIL stale_rise: got %b expected 1", stale); end
      end
    end
    an = 8'hFD; ca = 8'hF9;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs_v() !== exp_v()) begin n_fail++; $display("FAIL resume_model: got %h expected %h", obs_v(), exp_v()); end
      if (i == 18) begin
        n_cmp++;
        if (stale !== 1'b1) begin n_fail++; $display("FAIL stale_hold: got %b expected 1", stale); end
      end
      if (i == 19) begin
        n_cmp++;
        if (stale !== 1'b0) begin n_fail++; $display("FAIL stale_clear: got %b expected 0", stale); end
      end
    end
  endtask

  task automatic test_random();
    int len, kind, clr_at;
    logic [15:0] last;
    last = {ca, an};
    for (int s = 0; s < 60; s++) begin
      kind = $urandom_range(0, 9);
      if (kind < 6) an = 8'(~(8'b1 << $urandom_range(0, 7)));
      else if (kind < 8) an = 8'hFF;
      else an = 8'($urandom);
      if ($urandom_range(0, 3) == 0) ca = 8'($urandom);
      else ca = {1'($urandom), seg_tab[$urandom_range(0, 15)]};
      if ({ca, an} == last) ca[7] = ~ca[7];
      last = {ca, an};
      len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, S - 4) : $urandom_range(S + 4, S + 30);
      clr_at = ($urandom_range(0, 4) == 0) ? $urandom_range(1, len) : 0;
      for (int i = 1; i <= len; i++) begin
        clr = (i == clr_at);
        @(negedge clk);
        n_cmp++;
        if (obs_v() !== exp_v()) begin n_fail++; $display("FAIL random_model: got %h expected %h", obs_v(), exp_v()); end
      end
    end
    clr = 1'b0;
  endtask

  task automatic test_reset_midrun();
    an = 8'hFB; ca = 8'hC6;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs_v() !== exp_v()) begin n_fail++; $display("FAIL midrun_model: got %h expected %h", obs_v(), exp_v()); end
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs_v() !== 58'h0) begin n_fail++; $display("FAIL midrun_reset: got %h expected 0", obs_v()); end
    an = 8'hFF;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs_v() !== exp_v()) begin n_fail++; $display("FAIL midrun_after_model: got %h expected %h", obs_v(), exp_v()); end
    end
    n_cmp++;
    if (digits !== 32'h0 || valid !== 8'h00) begin n_fail++; $display("FAIL midrun_abort: got dig=%h valid=%h expected 0 00", digits, valid); end
  endtask

  initial begin
    test_reset();
    test_single_digit();
    test_glitch();
    test_illegal_blank();
    test_full_frame();
    test_clr_with_capture();
    test_stall();
    test_random();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg_scan_decoder.md
Name:
seg_scan_decoder

Overview:
- Passive monitor on the multiplexed 7-segment bus (CA cathodes, AN anodes) driven by the display scanner in `top`.
- Recovers the hex nibble and decimal point shown on each digit position and flags illegal cathode patterns.
- Reports frame completion and scan-stall conditions.
- Used in self-checking benches and as an on-board loopback checker; it sits in parallel with the board pins.

Parameters:
- NUM_DIGITS, 8: number of anode positions.
- SETTLE_CYCLES, 16: consecutive cycles a CA/AN pair must be stable before capture; range 2..255.
- TIMEOUT_CYCLES, 200000: cycles without a capture before STALE asserts; counter width is $clog2(TIMEOUT_CYCLES+1).
- SCAN_MASK, 8'hFF: digit positions that must be captured for a frame to count as complete.

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous, active-low reset
- CLR  in  1  synchronous pulse; clears VALID, ERR and frame tracking
- CA  in  8  cathodes, active-low; [7]=DP, [6:0]=g..a
- AN  in  NUM_DIGITS  anodes, active-low, one-hot when a digit is lit
- DIGITS  out  4*NUM_DIGITS  nibble of digit i at [4i+3:4i]
- DP  out  NUM_DIGITS  decimal point of digit i, 1 = lit
- VALID  out  NUM_DIGITS  digit i holds a decoded legal value
- ERR  out  NUM_DIGITS  sticky; illegal pattern seen on digit i
- FRAME_DONE  out  1  one-cycle pulse
- STALE  out  1  no capture for TIMEOUT_CYCLES

Behaviour:
- Reset (RST=0, async): DIGITS=0, DP=0, VALID=0, ERR=0, FRAME_DONE=0, STALE=0, FSM=SETTLE, counters=0, synchronizers=all ones.
- CA and AN each pass through a 2-flop synchronizer. The synchronized pair is compared to its value on the previous cycle.
- FSM states:
  - SETTLE: stability counter increments while the pair is unchanged and resets to 0 on any change. When the count reaches SETTLE_CYCLES-1, go to CAPTURE.
  - CAPTURE: lasts one cycle and updates registers if AN is one-hot-low. Always goes to HOLD.
  - HOLD: stays until the pair changes, then goes to SETTLE with the counter at 0. This gives exactly one capture per stable interval.
- Latency: if the pair is applied at the inputs before edge k and held, outputs update at edge k+SETTLE_CYCLES+2. A change lasting fewer than SETTLE_CYCLES cycles produces no capture.
- AN all ones (blanked) or more than one bit low: no capture and no error. The FSM still passes through CAPTURE to HOLD.
- Decode of CA[6:0] to nibble:
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7
  - 00→8, 10→9, 08→A, 03→B, 46→C, 21→D, 06→E, 0E→F
- Capture on digit i:
  - DP[i] = ~CA[7] in every case.
  - Legal pattern: DIGITS nibble i updated, VALID[i]=1.
  - CA[6:0]=7F (blank digit): VALID[i]=0, nibble unchanged, no error.
  - Any other pattern: ERR[i]=1 (sticky), VALID and nibble unchanged.
- Frame tracking:
  - A seen-mask register sets bit i on any capture of digit i (legal, blank or illegal).
  - When (seen | new bit) covers SCAN_MASK, FRAME_DONE pulses high on the same edge as the completing capture, and seen is cleared.
- STALE:
  - The idle counter resets on every capture and otherwise increments, saturating.
  - STALE=1 once the counter reaches TIMEOUT_CYCLES; it clears on the edge of the next capture.
- CLR:
  - Clears VALID, ERR and seen; DIGITS and DP are retained.
  - If CLR coincides with a capture, the capture result is applied after the clear. The captured digit's VALID/ERR/seen bits reflect the capture; all other bits are cleared.
- Asserting RST mid-capture aborts the capture; all outputs return to reset values immediately.

Test Plan:
- Reset: RST=0 with random CA/AN → all outputs 0; after release with AN=FF held 100 cycles → VALID=0, FRAME_DONE never pulses.
- Single digit: AN=FE, CA=8E held 40 cycles → at edge 18 after the apply edge, DIGITS[3:0]=F, VALID[0]=1, DP[0]=0. Then CA=0E → DP[0]=1.
- Glitch rejection: AN=FD with CA toggling C0/F9 every 8 cycles for 200 cycles → VALID[1]=0, DIGITS unchanged. Then hold CA=F9 → DIGITS[7:4]=1.
- Illegal/blank: AN=FB, CA=FF → VALID[2]=0, ERR=0. Then CA=AA → ERR[2]=1, which survives later legal captures until a CLR pulse clears it.
- Full frame: scan digits 0..7 with patterns for 0..7 at 50 cycles each → DIGITS=32'h76543210, VALID=FF, exactly one FRAME_DONE pulse, coincident with the digit-7 capture.
- Stall: with TIMEOUT_CYCLES=100, stop scanning (AN=FF) → STALE=1 exactly 100 cycles after the last capture. Resume scanning → STALE=0 at the next capture edge.
